// File: rtl/core_types_pkg.sv
// core_types_pkg: core-wide widths, ALU op encoding and the ALU-imm issue queue entry layout.
package core_types_pkg;
   localparam int LOG_PR_COUNT       = 7;
   localparam int LOG_ROB_ENTRIES    = 7;
   localparam int PRF_BANK_COUNT     = 4;
   localparam int LOG_PRF_BANK_COUNT = 2;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SLL  = 4'h1,
      ALU_SLT  = 4'h2,
      ALU_SLTU = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SRL  = 4'h5,
      ALU_OR   = 4'h6,
      ALU_AND  = 4'h7,
      ALU_SUB  = 4'h8,
      ALU_SRA  = 4'hD
   } alu_op_t;
   typedef struct packed {
      logic                       valid;
      logic [3:0]                 op;
      logic [11:0]                imm12;
      logic [LOG_PR_COUNT-1:0]    A_PR;
      logic                       A_ready;
      logic [LOG_PR_COUNT-1:0]    dest_PR;
      logic [LOG_ROB_ENTRIES-1:0] ROB_index;
   } alu_imm_iq_entry_t;
   function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(input logic [LOG_PR_COUNT-1:0] pr);
      return pr[LOG_PRF_BANK_COUNT-1:0];
   endfunction
   function automatic logic [LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] pr_upper(input logic [LOG_PR_COUNT-1:0] pr);
      return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
   endfunction
endpackage

// File: rtl/pe_lsb.sv
// pe_lsb: LSB-first priority encoder; the lowest set request bit wins.
module pe_lsb #(
   parameter int WIDTH     = 8,
   parameter int LOG_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]     req,
   output logic                 ack_valid,
   output logic [LOG_WIDTH-1:0] ack_index
);
   always_comb begin
      ack_valid = |req;
      ack_index = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) ack_index = LOG_WIDTH'(i);
      end
   end
endmodule

// File: rtl/alu_imm_iq.sv
// alu_imm_iq: compressing issue queue for ALU reg-imm ops; wakes operand A from the
// writeback bus and fast-forward notifs, issues the oldest ready op each cycle.
module alu_imm_iq
   import core_types_pkg::*;
#(
   parameter int ALU_IMM_IQ_ENTRIES          = 8,
   parameter int FAST_FORWARD_PIPE_COUNT     = 4,
   parameter int LOG_FAST_FORWARD_PIPE_COUNT = $clog2(FAST_FORWARD_PIPE_COUNT)
) (
   input  logic                                CLK,
   input  logic                                nRST,
   input  logic                                dispatch_valid,
   input  logic [3:0]                          dispatch_op,
   input  logic [11:0]                         dispatch_imm12,
   input  logic [LOG_PR_COUNT-1:0]             dispatch_A_PR,
   input  logic                                dispatch_A_ready,
   input  logic [LOG_PR_COUNT-1:0]             dispatch_dest_PR,
   input  logic [LOG_ROB_ENTRIES-1:0]          dispatch_ROB_index,
   output logic                                dispatch_ready,
   input  logic [PRF_BANK_COUNT-1:0]           WB_bus_valid_by_bank,
   input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
   input  logic [FAST_FORWARD_PIPE_COUNT-1:0]  fast_forward_notif_valid_by_pipe,
   input  logic [FAST_FORWARD_PIPE_COUNT-1:0][LOG_PR_COUNT-1:0] fast_forward_notif_PR_by_pipe,
   output logic                                issue_valid,
   output logic [3:0]                          issue_op,
   output logic [11:0]                         issue_imm12,
   output logic                                issue_A_is_reg,
   output logic                                issue_A_is_bus_forward,
   output logic                                issue_A_is_fast_forward,
   output logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] issue_A_fast_forward_pipe,
   output logic [LOG_PRF_BANK_COUNT-1:0]       issue_A_bank,
   output logic [LOG_PR_COUNT-1:0]             issue_dest_PR,
   output logic [LOG_ROB_ENTRIES-1:0]          issue_ROB_index,
   input  logic                                issue_ready,
   output logic                                PRF_req_A_valid,
   output logic [LOG_PR_COUNT-1:0]             PRF_req_A_PR
);
   localparam int N     = ALU_IMM_IQ_ENTRIES;
   localparam int LOG_N = $clog2(N);
   localparam int FF    = FAST_FORWARD_PIPE_COUNT;

   alu_imm_iq_entry_t entries_q [N];
   alu_imm_iq_entry_t entries_d [N];
   alu_imm_iq_entry_t upd [N+1];
   alu_imm_iq_entry_t new_entry;
   alu_imm_iq_entry_t sel_e;
   logic [N-1:0]      bus_match;
   logic [N-1:0]      ff_any;
   logic [N-1:0]      entry_ready;
   logic [FF-1:0]     ff_req [N];
   logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] ff_idx [N];
   logic [LOG_N-1:0]  sel;
   logic              dispatch_bus_match;
   logic              issue_fire;
   logic              dispatch_fire;
   logic              placed;

   for (genvar e = 0; e < N; e++) begin : g_entry
      assign bus_match[e] = WB_bus_valid_by_bank[pr_bank(entries_q[e].A_PR)]
         && WB_bus_upper_PR_by_bank[pr_bank(entries_q[e].A_PR)] == pr_upper(entries_q[e].A_PR);
      for (genvar p = 0; p < FF; p++) begin : g_pipe
         assign ff_req[e][p] = fast_forward_notif_valid_by_pipe[p]
            && fast_forward_notif_PR_by_pipe[p] == entries_q[e].A_PR;
      end
      pe_lsb #(.WIDTH(FF), .LOG_WIDTH(LOG_FAST_FORWARD_PIPE_COUNT)) u_ff_pe (
         .req       (ff_req[e]),
         .ack_valid (ff_any[e]),
         .ack_index (ff_idx[e])
      );
      assign entry_ready[e] = entries_q[e].valid && (entries_q[e].A_ready || bus_match[e] || ff_any[e]);
   end

   pe_lsb #(.WIDTH(N), .LOG_WIDTH(LOG_N)) u_sel_pe (
      .req       (entry_ready),
      .ack_valid (issue_valid),
      .ack_index (sel)
   );

   assign sel_e = entries_q[sel];
   assign issue_op = issue_valid ? sel_e.op : '0;
   assign issue_imm12 = issue_valid ? sel_e.imm12 : '0;
   assign issue_A_is_reg = issue_valid && sel_e.A_ready;
   assign issue_A_is_bus_forward = issue_valid && !sel_e.A_ready && bus_match[sel];
   assign issue_A_is_fast_forward = issue_valid && !sel_e.A_ready && !bus_match[sel];
   assign issue_A_fast_forward_pipe = issue_A_is_fast_forward ? ff_idx[sel] : '0;
   assign issue_A_bank = issue_valid ? pr_bank(sel_e.A_PR) : '0;
   assign issue_dest_PR = issue_valid ? sel_e.dest_PR : '0;
   assign issue_ROB_index = issue_valid ? sel_e.ROB_index : '0;
   assign PRF_req_A_valid = issue_A_is_reg && issue_ready;
   assign PRF_req_A_PR = issue_valid ? sel_e.A_PR : '0;

   // Entries stay packed from index 0, so the queue is full exactly when the top slot is used.
   assign dispatch_ready = !entries_q[N-1].valid;
   assign issue_fire = issue_valid && issue_ready;
   assign dispatch_fire = dispatch_valid && dispatch_ready;
   assign dispatch_bus_match = WB_bus_valid_by_bank[pr_bank(dispatch_A_PR)]
      && WB_bus_upper_PR_by_bank[pr_bank(dispatch_A_PR)] == pr_upper(dispatch_A_PR);
   assign new_entry = '{
      valid:     1'b1,
      op:        dispatch_op,
      imm12:     dispatch_imm12,
      A_PR:      dispatch_A_PR,
      A_ready:   dispatch_A_ready || dispatch_bus_match,
      dest_PR:   dispatch_dest_PR,
      ROB_index: dispatch_ROB_index
   };

   // upd[N] is an always-empty slot that the top entry pulls in when the queue shifts down.
   always_comb begin
      upd[N] = '0;
      for (int i = 0; i < N; i++) begin
         upd[i] = entries_q[i];
         upd[i].A_ready = entries_q[i].A_ready || bus_match[i];
      end
      placed = 1'b0;
      for (int i = 0; i < N; i++) begin
         entries_d[i] = upd[(issue_fire && i >= int'(sel)) ? i + 1 : i];
         if (dispatch_fire && !entries_d[i].valid && !placed) begin
            entries_d[i] = new_entry;
            placed = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < N; i++) entries_q[i] <= '0;
      end else begin
         entries_q <= entries_d;
      end
   end
endmodule

// File: doc/alu_imm_iq.md
Name: alu_imm_iq

Overview:
Issue queue directly upstream of the ALU register-immediate pipeline.
- Accepts one dispatched ALU-imm op per cycle and holds it until its source operand A is available.
- Wakes A from the PRF writeback bus and from fast-forward notifications.
- Issues the oldest ready op per cycle, with operand-source tags that the pipeline's operand collector consumes directly.
- Compressing (shifting) queue: entry 0 is always the oldest.

Parameters:
ALU_IMM_IQ_ENTRIES, 8, number of queue entries.
FAST_FORWARD_PIPE_COUNT, 4, number of pipes broadcasting fast-forward notifs.
LOG_FAST_FORWARD_PIPE_COUNT, $clog2(FAST_FORWARD_PIPE_COUNT), pipe index width.

Ports:
CLK  in  1  clock.
nRST  in  1  asynchronous active-low reset.
dispatch_valid  in  1  dispatch request.
dispatch_op  in  4  ALU op.
dispatch_imm12  in  12  immediate.
dispatch_A_PR  in  LOG_PR_COUNT  source A physical register.
dispatch_A_ready  in  1  A is already written in the PRF.
dispatch_dest_PR  in  LOG_PR_COUNT  destination PR.
dispatch_ROB_index  in  LOG_ROB_ENTRIES  ROB index.
dispatch_ready  out  1  queue can accept this cycle.
WB_bus_valid_by_bank  in  PRF_BANK_COUNT  writeback bus valid, per bank.
WB_bus_upper_PR_by_bank  in  PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  written PR with bank bits removed.
fast_forward_notif_valid_by_pipe  in  FAST_FORWARD_PIPE_COUNT  notif valid.
fast_forward_notif_PR_by_pipe  in  FAST_FORWARD_PIPE_COUNT x LOG_PR_COUNT  notif PR.
issue_valid, issue_op[4], issue_imm12[12], issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward  out  issue payload to the pipeline.
issue_A_fast_forward_pipe  out  LOG_FAST_FORWARD_PIPE_COUNT  matching pipe.
issue_A_bank  out  LOG_PRF_BANK_COUNT  A_PR[LOG_PRF_BANK_COUNT-1:0].
issue_dest_PR, issue_ROB_index  out  as dispatch widths.
issue_ready  in  1  pipeline backpressure.
PRF_req_A_valid  out  1  PRF read request for the issued A.
PRF_req_A_PR  out  LOG_PR_COUNT  PR to read.

Behaviour:
- Reset:
  - All entry valid bits 0.
  - issue_valid=0, PRF_req_A_valid=0, all issue payload outputs 0.
  - dispatch_ready=1.
- Per-entry state: valid, op, imm12, A_PR, A_ready, dest_PR, ROB_index.
- Bus match for a PR: WB_bus_valid_by_bank[PR bank bits] and WB_bus_upper_PR_by_bank[bank] == PR upper bits.
- Fast-forward match: any pipe p with notif_valid[p] and notif_PR[p] == A_PR. Lowest p wins.
- Entry ready = valid & (A_ready | bus match | fast-forward match).
- Source priority for a ready entry is reg > bus forward > fast forward. Exactly one issue_A_is_* is set when issue_valid=1.
- Select: lowest-index ready entry. All issue outputs are combinational from registered state plus this cycle's wakeup inputs.
  - issue_valid = any entry ready.
  - issue_A_fast_forward_pipe is valid only when is_fast_forward is set.
  - PRF_req_A_valid = issue_valid & issue_ready & issue_A_is_reg.
  - PRF_req_A_PR = selected A_PR.
- Issue fires on issue_valid & issue_ready. The selected entry is removed, and entries above it shift down one index at the clock edge.
- When not issued, an entry still sets A_ready on a bus match; the value is now in the PRF.
  - A fast-forward match alone does not set A_ready: the notif lasts one cycle.
  - An entry missing its fast-forward cycle waits for its bus match.
- issue_ready=0:
  - No removal.
  - All issue outputs still reflect the selection; PRF_req_A_valid=0.
  - Wakeup updates continue.
- dispatch_ready = not all entries valid, from registered state; a same-cycle issue is not counted.
- Dispatch fires on dispatch_valid & dispatch_ready.
  - Writes the lowest free index after this cycle's compaction.
  - Stored A_ready = dispatch_A_ready | bus match on dispatch_A_PR this cycle.
- A dispatched op never issues in its dispatch cycle. Earliest issue is the next cycle.
- Simultaneous dispatch and issue when full is prevented, since dispatch_ready=0.
- Simultaneous dispatch and issue when not full: shift and insert in the same edge; the order is preserved.
- A_PR == 0: treated like any PR. The dispatcher marks it A_ready.
- Reset mid-operation clears all entries immediately (asynchronous); outputs go to reset values.

Decomposition:
- LOG_PR_COUNT, LOG_ROB_ENTRIES, PRF_BANK_COUNT and LOG_PRF_BANK_COUNT come from core_types_pkg.
- Add an alu_imm_iq_entry_t struct typedef to core_types_pkg.
- One natural sub-module: pe_lsb, an LSB-first priority encoder, reused for both the entry select and the fast-forward pipe select.

Test Plan:
- Dispatch op=ADD, imm12=0x005, A_PR=12, A_ready=1 into an empty queue with issue_ready=1 -> the next cycle shows issue_valid=1, is_reg=1, PRF_req_A_PR=12, bank=12 mod banks. The following cycle the queue is empty.
- Dispatch A_PR=20, A_ready=0, then a fast-forward notif on pipe 2 with PR 20 -> in that cycle issue_A_is_fast_forward=1 and issue_A_fast_forward_pipe=2.
- Same as the previous case but issue_ready=0 during the notif -> no issue. A later bus match on PR 20 -> is_bus_forward that cycle, then the entry issues as is_reg.
- Fill all 8 entries with A_ready=0 -> dispatch_ready=0. Bus-wake entry 3 -> it issues. The next cycle dispatch_ready=1, and entries 4-7 have shifted to 3-6 in order.
- Entries 0 and 2 both ready -> entry 0 issues first, then entry 2 (now at index 1) issues the following cycle.
- Dispatch with A_ready=0 in the same cycle as a bus match on its A_PR -> the entry stores A_ready=1 and issues next cycle with is_reg=1.
